// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing for the 5-stage core: PC/latch enables and flushes from load-use, cache waits, branches and halt.
// Enables/flushes are combinational from state and inputs (zero latency); state, counters and sticky flags are registered.
module hazard_stall_ctrl #(
    parameter int CNT_W     = 32,
    parameter int DWAIT_MAX = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rd,
    input  logic             exMemRead,
    input  logic             ihit,
    input  logic             mem_req,
    input  logic             dhit,
    input  logic             br_taken,
    input  logic             halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic             dwait_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(DWAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(DWAIT_MAX);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DWAIT = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  flush_q;
    logic              load_use;
    logic              flush_ev;

    // A load writing r0 never produces a value anyone can depend on.
    assign load_use = exMemRead && (ex_rd != 5'd0) && ((ex_rd == id_rs) || (ex_rd == id_rt));

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_d     = state_q;
        wait_d      = wait_q;
        flush_ev    = 1'b0;

        if (RST) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
            state_d = S_RUN;
            wait_d  = '0;
        end else if (state_q == S_HALT) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        end else if ((state_q == S_DWAIT) && !dhit) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            wait_d = (wait_q == WAIT_LIMIT) ? wait_q : wait_q + 1'b1;
        end else begin
            // RUN, or the completing cycle of a D-wait (which skips the miss rule).
            state_d = S_RUN;
            wait_d  = '0;
            if (halt) begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00001;
                {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
                state_d = S_HALT;
            end else if ((state_q == S_RUN) && mem_req && !dhit) begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
                state_d = S_DWAIT;
            end else if (br_taken) begin
                {ifid_flush, idex_flush, exmem_flush} = 3'b111;
                flush_ev = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (!ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (wait_d == WAIT_LIMIT) begin
                err_q <= 1'b1;
            end
            if ((state_q != S_HALT) && !pc_en && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (flush_ev && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    // Observed values read as reset values for the whole cycle RST is high.
    assign halted    = (state_q == S_HALT) && !RST;
    assign dwait_err = err_q && !RST;
    assign stall_cnt = RST ? '0 : stall_q;
    assign flush_cnt = RST ? '0 : flush_q;

endmodule
